// File: rtl/leb128_enc_i32_if.sv
// Byte-stream interface for the LEB128 encoder.
// Input side : in_data[31:0], in_valid, in_ready (value handshake)
// Output side: out_data[7:0], out_valid, out_ready, out_last, out_idx[2:0]
// master = value producer / byte consumer, slave = encoder.
interface leb128_enc_i32_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [2:0]  out_idx;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_idx
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_idx
  );
endinterface

// File: rtl/leb128_enc_i32.sv
// Serial LEB128 encoder: takes one 32-bit value per transaction and emits its
// LEB128 bytes one per cycle on a valid/ready stream.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - leb128_enc_i32_if.slave (value input handshake, byte output stream)
// Parameter SIGNED: 1 = SLEB128 (arithmetic shift, sign-aware end),
//                   0 = ULEB128 (logical shift, zero end).
// Optional macro LEB128_ENC_PAD5_EN: always emit exactly 5 bytes (padded).
module leb128_enc_i32 #(
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  leb128_enc_i32_if.slave   bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LAST_IDX = 4;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   v_q, v_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [DATA_W-1:0]   r_c;
  logic                done_c;

  // Remaining value after the current 7-bit group is consumed.
  assign r_c = SIGNED ? $unsigned($signed(v_q) >>> 7) : (v_q >> 7);

  // Last byte: padded mode stops at a fixed index, otherwise once the
  // remainder is pure sign/zero extension of the emitted payload.
`ifdef LEB128_ENC_PAD5_EN
  assign done_c = (idx_q == IDX_W'(LAST_IDX));
`else
  always_comb begin
    if (SIGNED) begin
      done_c = ((r_c == '0) && !v_q[6]) || ((r_c == '1) && v_q[6]);
    end else begin
      done_c = (r_c == '0);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and stream outputs; outputs are a direct function of V/idx.
  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    idx_d         = idx_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.out_idx   = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          v_d     = bus.in_data;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = BYTE_W'({~done_c, v_q[6:0]});
        bus.out_last  = done_c;
        bus.out_idx   = idx_q;
        // Without out_ready everything holds, so the byte stays stable.
        if (bus.out_ready) begin
          if (done_c) begin
            state_d = S_IDLE;
          end else begin
            v_d   = r_c;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_leb128_enc_i32.sv
module tb_leb128_enc_i32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Stimulus shared by both encoders, routed to the one selected by sel.
  logic        sel;        // 1 = signed encoder, 0 = unsigned encoder
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;

  leb128_enc_i32_if bus_s ();
  leb128_enc_i32_if bus_u ();

  assign bus_s.in_data   = in_data;
  assign bus_s.in_valid  = sel & in_valid;
  assign bus_s.out_ready = sel & out_ready;
  assign bus_u.in_data   = in_data;
  assign bus_u.in_valid  = ~sel & in_valid;
  assign bus_u.out_ready = ~sel & out_ready;

  leb128_enc_i32 #(.SIGNED(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));
  leb128_enc_i32 #(.SIGNED(1'b0)) dut_u (.clk(clk), .reset(reset), .bus(bus_u));

  logic [7:0] o_data;
  logic       o_valid, o_last, o_in_ready;
  logic [2:0] o_idx;
  assign o_data     = sel ? bus_s.out_data  : bus_u.out_data;
  assign o_valid    = sel ? bus_s.out_valid : bus_u.out_valid;
  assign o_last     = sel ? bus_s.out_last  : bus_u.out_last;
  assign o_idx      = sel ? bus_s.out_idx   : bus_u.out_idx;
  assign o_in_ready = sel ? bus_s.in_ready  : bus_u.in_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Byte 4 must always be the final byte.
  always @(negedge clk) begin
    if (!reset && o_valid && o_idx == 3'd4) begin
      n_checks++;
      if (!o_last) begin
        n_fail++;
        $display("FAIL idx4_not_last: sel=%0d data=%02h last=%0d required last=1", sel, o_data, o_last);
      end
    end
  end

  // Reference encoding from integer arithmetic: peel 7-bit groups by exact
  // floor division until the rest is pure sign (or zero) extension.
  function automatic void model(input bit sgn, input logic [31:0] val,
                                output logic [39:0] bytes, output int n);
    longint x;
    logic [6:0] p;
    bit done;
    x = sgn ? longint'($signed(val)) : longint'({32'd0, val});
    bytes = '0;
    n = 0;
    done = 1'b0;
    while (!done) begin
      p = 7'(x & 64'd127);
      x = (x - longint'(p)) / 128;
`ifdef LEB128_ENC_PAD5_EN
      done = (n == 4);
`else
      done = sgn ? ((x == 0 && !p[6]) || (x == -1 && p[6])) : (x == 0);
`endif
      bytes[8*n +: 8] = {~done, p};
      n++;
    end
  endfunction

  // One full transaction on the selected encoder, starting and ending on a
  // falling edge. Records accepted bytes and protocol-shape observations.
  task automatic xfer(input logic [31:0] val, input int stall_pct,
                      output logic [39:0] bytes, output int n,
                      output bit shape_ok, output bit lat_ok, output bit tmo);
    int guard;
    bit fin;
    bytes = '0; n = 0; shape_ok = 1'b1; lat_ok = 1'b1; tmo = 1'b0; fin = 1'b0;
    guard = 0;
    while (!o_in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!o_in_ready) begin
      tmo = 1'b1;
      return;
    end
    in_data = val;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = $urandom();
    lat_ok = o_valid;
    guard = 0;
    while (!fin && guard < 60) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_ready && o_valid) begin
        if (n < 5) bytes[8*n +: 8] = o_data;
        if (o_idx != 3'(n)) shape_ok = 1'b0;
        if (o_last != !o_data[7]) shape_ok = 1'b0;
        n++;
        fin = o_last;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    if (!fin) tmo = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      n_checks++;
      if ({o_in_ready, o_valid, o_last, o_data, o_idx} !== {1'b1, 1'b0, 1'b0, 8'h00, 3'd0}) begin
        n_fail++;
        $display("FAIL reset_state: sel=%0d rdy=%0d vld=%0d last=%0d data=%02h idx=%0d required 1 0 0 00 0",
                 sel, o_in_ready, o_valid, o_last, o_data, o_idx);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
`ifdef LEB128_ENC_PAD5_EN
    localparam int NV = 5;
    bit          sg [NV] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] vv [NV] = '{32'd3, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd128};
    logic [39:0] ev [NV] = '{40'h0080808083, 40'h7FFFFFFFFE, 40'h0080808080, 40'h7FFFFFFFFF, 40'h0080808180};
    int          en [NV] = '{5, 5, 5, 5, 5};
`else
    localparam int NV = 10;
    bit          sg [NV] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [31:0] vv [NV] = '{32'd0, 32'hFFFFFFFF, 32'd63, 32'd64, 32'hFFFFFFC0, 32'hFFFFFFBF,
                             32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd128};
    logic [39:0] ev [NV] = '{40'h00, 40'h7F, 40'h3F, 40'h00C0, 40'h40, 40'h7FBF,
                             40'h07FFFFFFFF, 40'h7880808080, 40'h0FFFFFFFFF, 40'h0180};
    int          en [NV] = '{1, 1, 1, 2, 1, 2, 5, 5, 5, 2};
`endif
    logic [39:0] got;
    int n;
    bit shp, lat, tmo;
    for (int i = 0; i < NV; i++) begin
      sel = sg[i];
      @(negedge clk);
      xfer(vv[i], 0, got, n, shp, lat, tmo);
      n_checks++;
      if (tmo || !shp || !lat || n != en[i] || got !== ev[i]) begin
        n_fail++;
        $display("FAIL vector[%0d]: val=%08h got=%010h n=%0d shape=%0d lat=%0d tmo=%0d required %010h n=%0d",
                 i, vv[i], got, n, shp, lat, tmo, ev[i], en[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] got, exp;
    int n, en;
    bit shp, lat, tmo;
    sel = 1'b1;
    @(negedge clk);
    xfer(32'd624485, 0, got, n, shp, lat, tmo);
    model(1'b1, 32'd624485, exp, en);
    n_checks++;
    if (tmo || !shp || !lat || n != en || got !== exp) begin
      n_fail++;
      $display("FAIL b2b_first: got=%010h n=%0d required %010h n=%0d", got, n, exp, en);
    end
    n_checks++;
    if (o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: in_ready=%0d out_valid=%0d required 1 0", o_in_ready, o_valid);
    end
    xfer(32'hFFFE1DC0, 0, got, n, shp, lat, tmo);
    model(1'b1, 32'hFFFE1DC0, exp, en);
    n_checks++;
    if (tmo || !shp || !lat || n != en || got !== exp) begin
      n_fail++;
      $display("FAIL b2b_second: got=%010h n=%0d lat=%0d required %010h n=%0d lat=1", got, n, lat, exp, en);
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] got, exp;
    int n, en, guard;
    bit fin;
    sel = 1'b1;
    @(negedge clk);
    in_data = 32'd624485; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = '0; n = 0; fin = 1'b0;
    out_ready = 1'b1;
    got[7:0] = o_data; n = 1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h8E || o_idx !== 3'd1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: vld=%0d data=%02h idx=%0d required 1 8e 1", k, o_valid, o_data, o_idx);
      end
    end
    out_ready = 1'b1;
    guard = 0;
    while (!fin && guard < 20) begin
      if (o_valid) begin
        if (n < 5) got[8*n +: 8] = o_data;
        n++;
        fin = o_last;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    model(1'b1, 32'd624485, exp, en);
    n_checks++;
    if (!fin || n != en || got !== exp) begin
      n_fail++;
      $display("FAIL stall_seq: got=%010h n=%0d fin=%0d required %010h n=%0d", got, n, fin, exp, en);
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] got, exp;
    int n, en;
    bit shp, lat, tmo;
    sel = 1'b1;
    @(negedge clk);
    in_data = 32'h7FFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (o_idx !== 3'd2 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: idx=%0d vld=%0d required 2 1", o_idx, o_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: vld=%0d in_ready=%0d required 0 1", o_valid, o_in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: vld=%0d required 0", o_valid);
    end
    xfer(32'd5, 0, got, n, shp, lat, tmo);
    model(1'b1, 32'd5, exp, en);
    n_checks++;
    if (tmo || !shp || !lat || n != en || got !== exp) begin
      n_fail++;
      $display("FAIL midrst_after: got=%010h n=%0d required %010h n=%0d", got, n, exp, en);
    end
  endtask

  task automatic test_random();
    logic [39:0] got, exp;
    logic [31:0] v;
    int n, en;
    bit shp, lat, tmo;
    for (int i = 0; i < 300; i++) begin
      sel = i[0];
      case ($urandom_range(3))
        0: v = $urandom();
        1: v = 32'($urandom_range(300));
        2: v = -32'($urandom_range(300));
        default: v = $urandom() >> $urandom_range(31);
      endcase
      @(negedge clk);
      xfer(v, 30, got, n, shp, lat, tmo);
      model(sel, v, exp, en);
      n_checks++;
      if (tmo || n != en || got !== exp) begin
        n_fail++;
        $display("FAIL rand_bytes[%0d]: sel=%0d val=%08h got=%010h n=%0d tmo=%0d required %010h n=%0d",
                 i, sel, v, got, n, tmo, exp, en);
      end
      n_checks++;
      if (!shp || !lat) begin
        n_fail++;
        $display("FAIL rand_shape[%0d]: sel=%0d val=%08h shape=%0d lat=%0d required 1 1", i, sel, v, shp, lat);
      end
    end
  endtask

  initial begin
    sel = 1'b1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
